// File: rtl/el2_lsu_fault_pipe_if.sv
// el2_lsu_fault_pipe_if
// Bundles the D-stage fault-check packet, pipeline control, the R-stage
// LSU error packet and the sticky capture / counter outputs of
// el2_lsu_fault_pipe.
//   master : address-check / TLU side (drives D packet, freeze, flush, ack)
//   slave  : el2_lsu_fault_pipe (drives error packet, capture, counter)
interface el2_lsu_fault_pipe_if #(
  parameter int AW    = 32,
  parameter int CNT_W = 8
);
  // D-stage packet from the address checker
  logic             lsu_pkt_valid_d;
  logic             lsu_pkt_store_d;
  logic             lsu_pkt_dma_d;
  logic             lsu_pkt_fast_int_d;
  logic             access_fault_d;
  logic             misaligned_fault_d;
  logic [3:0]       exc_mscause_d;
  logic             fir_dccm_access_error_d;
  logic             fir_nondccm_access_error_d;
  logic [AW-1:0]    start_addr_d;
  // pipeline control / acknowledge
  logic             lsu_freeze;
  logic             dec_tlu_flush_lower_r;
  logic             err_ack;
  // R-stage error packet
  logic             lsu_error_valid_r;
  logic             lsu_error_misaligned_r;
  logic             lsu_error_store_r;
  logic [3:0]       lsu_error_mscause_r;
  logic [AW-1:0]    lsu_error_addr_r;
  logic [1:0]       lsu_fir_error_r;
  // sticky capture and counter
  logic             err_pending;
  logic [3:0]       err_cap_mscause;
  logic [AW-1:0]    err_cap_addr;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output lsu_pkt_valid_d, lsu_pkt_store_d, lsu_pkt_dma_d, lsu_pkt_fast_int_d,
           access_fault_d, misaligned_fault_d, exc_mscause_d,
           fir_dccm_access_error_d, fir_nondccm_access_error_d, start_addr_d,
           lsu_freeze, dec_tlu_flush_lower_r, err_ack,
    input  lsu_error_valid_r, lsu_error_misaligned_r, lsu_error_store_r,
           lsu_error_mscause_r, lsu_error_addr_r, lsu_fir_error_r,
           err_pending, err_cap_mscause, err_cap_addr, err_cnt
  );

  modport slave (
    input  lsu_pkt_valid_d, lsu_pkt_store_d, lsu_pkt_dma_d, lsu_pkt_fast_int_d,
           access_fault_d, misaligned_fault_d, exc_mscause_d,
           fir_dccm_access_error_d, fir_nondccm_access_error_d, start_addr_d,
           lsu_freeze, dec_tlu_flush_lower_r, err_ack,
    output lsu_error_valid_r, lsu_error_misaligned_r, lsu_error_store_r,
           lsu_error_mscause_r, lsu_error_addr_r, lsu_fir_error_r,
           err_pending, err_cap_mscause, err_cap_addr, err_cnt
  );
endinterface

// File: rtl/el2_lsu_fault_pipe.sv
// el2_lsu_fault_pipe
// Carries per-access fault results from D through M to R and presents one
// architectural LSU error packet to the trap logic. Also keeps a sticky
// first-error capture (mscause/address) and a saturating error counter.
// Ports:
//   clk  - core clock
//   rst  - asynchronous active-high reset
//   bus  - el2_lsu_fault_pipe_if.slave (D packet in, R packet / capture out)
module el2_lsu_fault_pipe #(
  parameter int AW    = 32,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  el2_lsu_fault_pipe_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             m_valid_q, m_valid_d, r_valid_q, r_valid_d;
  logic             m_fault_q, m_fault_d, r_fault_q, r_fault_d;
  logic             m_mis_q, m_mis_d, r_mis_q, r_mis_d;
  logic             m_store_q, m_store_d, r_store_q, r_store_d;
  logic [3:0]       m_cause_q, m_cause_d, r_cause_q, r_cause_d;
  logic [AW-1:0]    m_addr_q, m_addr_d, r_addr_q, r_addr_d;
  logic [1:0]       m_fir_q, m_fir_d, r_fir_q, r_fir_d;
  logic             pend_q, pend_d;
  logic [3:0]       cap_cause_q, cap_cause_d;
  logic [AW-1:0]    cap_addr_q, cap_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             freeze, flush, err_valid, cap_en;
  logic [1:0]       d_fir;

  assign freeze = bus.lsu_freeze;
  assign flush  = bus.dec_tlu_flush_lower_r;

  // DCCM error wins when both fast-int error sources fire
  assign d_fir = ~bus.lsu_pkt_fast_int_d       ? 2'b00 :
                 bus.fir_dccm_access_error_d    ? 2'b01 :
                 bus.fir_nondccm_access_error_d ? 2'b10 : 2'b00;

  always_comb begin
    // payloads advance only when unfrozen; flush clears valids even when frozen
    m_fault_d = freeze ? m_fault_q : (bus.access_fault_d | bus.misaligned_fault_d);
    m_mis_d   = freeze ? m_mis_q   : bus.misaligned_fault_d;
    m_store_d = freeze ? m_store_q : bus.lsu_pkt_store_d;
    m_cause_d = freeze ? m_cause_q : bus.exc_mscause_d;
    m_addr_d  = freeze ? m_addr_q  : bus.start_addr_d;
    m_fir_d   = freeze ? m_fir_q   : d_fir;
    r_fault_d = freeze ? r_fault_q : m_fault_q;
    r_mis_d   = freeze ? r_mis_q   : m_mis_q;
    r_store_d = freeze ? r_store_q : m_store_q;
    r_cause_d = freeze ? r_cause_q : m_cause_q;
    r_addr_d  = freeze ? r_addr_q  : m_addr_q;
    r_fir_d   = freeze ? r_fir_q   : m_fir_q;
    m_valid_d = flush ? 1'b0 : freeze ? m_valid_q
                             : (bus.lsu_pkt_valid_d & ~bus.lsu_pkt_dma_d);
    r_valid_d = flush ? 1'b0 : freeze ? r_valid_q : m_valid_q;
  end

  assign err_valid = r_valid_q & r_fault_q;

  // a frozen R error is seen repeatedly; only the unfrozen cycle counts
  assign cap_en      = err_valid & ~freeze & (~pend_q | bus.err_ack);
  assign pend_d      = cap_en | (pend_q & ~bus.err_ack);
  assign cap_cause_d = cap_en ? r_cause_q : cap_cause_q;
  assign cap_addr_d  = cap_en ? r_addr_q  : cap_addr_q;
  assign cnt_d       = (err_valid & ~freeze & ~(&cnt_q)) ? cnt_q + CNT_ONE : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q   <= 1'b0;  r_valid_q <= 1'b0;
      m_fault_q   <= 1'b0;  r_fault_q <= 1'b0;
      m_mis_q     <= 1'b0;  r_mis_q   <= 1'b0;
      m_store_q   <= 1'b0;  r_store_q <= 1'b0;
      m_cause_q   <= '0;    r_cause_q <= '0;
      m_addr_q    <= '0;    r_addr_q  <= '0;
      m_fir_q     <= '0;    r_fir_q   <= '0;
      pend_q      <= 1'b0;
      cap_cause_q <= '0;
      cap_addr_q  <= '0;
      cnt_q       <= '0;
    end else begin
      m_valid_q   <= m_valid_d;  r_valid_q <= r_valid_d;
      m_fault_q   <= m_fault_d;  r_fault_q <= r_fault_d;
      m_mis_q     <= m_mis_d;    r_mis_q   <= r_mis_d;
      m_store_q   <= m_store_d;  r_store_q <= r_store_d;
      m_cause_q   <= m_cause_d;  r_cause_q <= r_cause_d;
      m_addr_q    <= m_addr_d;   r_addr_q  <= r_addr_d;
      m_fir_q     <= m_fir_d;    r_fir_q   <= r_fir_d;
      pend_q      <= pend_d;
      cap_cause_q <= cap_cause_d;
      cap_addr_q  <= cap_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.lsu_error_valid_r      = err_valid;
  assign bus.lsu_error_misaligned_r = err_valid & r_mis_q;
  assign bus.lsu_error_store_r      = err_valid & r_store_q;
  assign bus.lsu_error_mscause_r    = err_valid ? r_cause_q : 4'h0;
  assign bus.lsu_error_addr_r       = err_valid ? r_addr_q  : '0;
  assign bus.lsu_fir_error_r        = r_valid_q ? r_fir_q   : 2'b00;
  assign bus.err_pending            = pend_q;
  assign bus.err_cap_mscause        = cap_cause_q;
  assign bus.err_cap_addr           = cap_addr_q;
  assign bus.err_cnt                = cnt_q;

endmodule

// File: tb/tb_el2_lsu_fault_pipe.sv
// tb_el2_lsu_fault_pipe
// Randomized and directed stimulus against a packet-level reference model
// of the D->M->R error pipeline, sticky capture and saturating counter.
module tb_el2_lsu_fault_pipe;
  localparam int AW    = 32;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  el2_lsu_fault_pipe_if #(.AW(AW), .CNT_W(CNT_W)) bus ();
  el2_lsu_fault_pipe #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit        v;
    bit        f;
    bit        mis;
    bit        st;
    bit [3:0]  c;
    bit [31:0] a;
    bit [1:0]  fir;
  } pkt_t;

  // reference model: one packet per stage plus capture/counter state
  pkt_t      md_m, md_r;
  bit        md_pend;
  bit [3:0]  md_cc;
  bit [31:0] md_ca;
  int        md_cnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic pkt_t empty_pkt();
    pkt_t p;
    p.v = 0; p.f = 0; p.mis = 0; p.st = 0; p.c = 0; p.a = 0; p.fir = 0;
    return p;
  endfunction

  task automatic model_reset();
    md_m = empty_pkt(); md_r = empty_pkt();
    md_pend = 0; md_cc = 0; md_ca = 0; md_cnt = 0;
  endtask

  // what the D stage presents this cycle, as a packet
  function automatic pkt_t d_pkt();
    pkt_t p;
    p.v   = bus.lsu_pkt_valid_d && !bus.lsu_pkt_dma_d;
    p.f   = bus.access_fault_d || bus.misaligned_fault_d;
    p.mis = bus.misaligned_fault_d;
    p.st  = bus.lsu_pkt_store_d;
    p.c   = bus.exc_mscause_d;
    p.a   = bus.start_addr_d;
    if (!bus.lsu_pkt_fast_int_d)              p.fir = 0;
    else if (bus.fir_dccm_access_error_d)     p.fir = 1;
    else if (bus.fir_nondccm_access_error_d)  p.fir = 2;
    else                                      p.fir = 0;
    return p;
  endfunction

  task automatic check_all();
    bit ev;
    ev = md_r.v && md_r.f;
    chk("valid_r",  bus.lsu_error_valid_r, ev);
    chk("mis_r",    bus.lsu_error_misaligned_r, ev ? md_r.mis : 0);
    chk("store_r",  bus.lsu_error_store_r, ev ? md_r.st : 0);
    chk("cause_r",  bus.lsu_error_mscause_r, ev ? md_r.c : 0);
    chk("addr_r",   bus.lsu_error_addr_r, ev ? md_r.a : 0);
    chk("fir_r",    bus.lsu_fir_error_r, md_r.v ? md_r.fir : 0);
    chk("pending",  bus.err_pending, md_pend);
    chk("cap_cause", bus.err_cap_mscause, md_cc);
    chk("cap_addr", bus.err_cap_addr, md_ca);
    chk("err_cnt",  bus.err_cnt, md_cnt);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},   bus.lsu_error_valid_r, 0);
    chk({tag, "_mis"},     bus.lsu_error_misaligned_r, 0);
    chk({tag, "_store"},   bus.lsu_error_store_r, 0);
    chk({tag, "_cause"},   bus.lsu_error_mscause_r, 0);
    chk({tag, "_addr"},    bus.lsu_error_addr_r, 0);
    chk({tag, "_fir"},     bus.lsu_fir_error_r, 0);
    chk({tag, "_pending"}, bus.err_pending, 0);
    chk({tag, "_capc"},    bus.err_cap_mscause, 0);
    chk({tag, "_capa"},    bus.err_cap_addr, 0);
    chk({tag, "_cnt"},     bus.err_cnt, 0);
  endtask

  // one clock: advance the model with the inputs now on the bus, then compare
  task automatic step();
    pkt_t nm, nr;
    bit ev, frz, fl, ack, npend;
    bit [3:0] ncc;
    bit [31:0] nca;
    int ncnt;
    frz = bus.lsu_freeze; fl = bus.dec_tlu_flush_lower_r; ack = bus.err_ack;
    ev = md_r.v && md_r.f;
    npend = md_pend; ncc = md_cc; nca = md_ca; ncnt = md_cnt;
    if (ev && !frz && (!md_pend || ack)) begin
      npend = 1; ncc = md_r.c; nca = md_r.a;
    end else if (ack) begin
      npend = 0;
    end
    if (ev && !frz && md_cnt < 255) ncnt = md_cnt + 1;
    if (frz) begin nm = md_m;    nr = md_r; end
    else     begin nm = d_pkt(); nr = md_m; end
    if (fl) begin nm.v = 0; nr.v = 0; end
    @(posedge clk);
    md_m = nm; md_r = nr; md_pend = npend; md_cc = ncc; md_ca = nca; md_cnt = ncnt;
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_in();
    bus.lsu_pkt_valid_d = 0; bus.lsu_pkt_store_d = 0; bus.lsu_pkt_dma_d = 0;
    bus.lsu_pkt_fast_int_d = 0; bus.access_fault_d = 0; bus.misaligned_fault_d = 0;
    bus.exc_mscause_d = 0; bus.fir_dccm_access_error_d = 0;
    bus.fir_nondccm_access_error_d = 0; bus.start_addr_d = 0;
    bus.lsu_freeze = 0; bus.dec_tlu_flush_lower_r = 0; bus.err_ack = 0;
  endtask

  task automatic set_fault(input bit mis, input bit st, input bit [3:0] c, input bit [31:0] a);
    bus.lsu_pkt_valid_d = 1; bus.lsu_pkt_store_d = st;
    bus.access_fault_d = !mis; bus.misaligned_fault_d = mis;
    bus.exc_mscause_d = c; bus.start_addr_d = a;
  endtask

  task automatic rand_in();
    bus.lsu_pkt_valid_d            = ($urandom_range(0, 3) != 0);
    bus.lsu_pkt_store_d            = $urandom_range(0, 1);
    bus.lsu_pkt_dma_d              = ($urandom_range(0, 6) == 0);
    bus.lsu_pkt_fast_int_d         = ($urandom_range(0, 4) == 0);
    bus.access_fault_d             = ($urandom_range(0, 2) == 0);
    bus.misaligned_fault_d         = ($urandom_range(0, 3) == 0);
    bus.exc_mscause_d              = 4'($urandom);
    bus.fir_dccm_access_error_d    = $urandom_range(0, 1);
    bus.fir_nondccm_access_error_d = $urandom_range(0, 1);
    bus.start_addr_d               = $urandom;
    bus.lsu_freeze                 = ($urandom_range(0, 4) == 0);
    bus.dec_tlu_flush_lower_r      = ($urandom_range(0, 9) == 0);
    bus.err_ack                    = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    int cnt0;
    clear_in();
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 0;

    // misaligned load reaches R two edges later, capture/count one after
    set_fault(1, 0, 4'd2, 32'h2000_0001);
    step();
    clear_in();
    step();
    chk("dir_valid", bus.lsu_error_valid_r, 1);
    chk("dir_mis",   bus.lsu_error_misaligned_r, 1);
    chk("dir_cause", bus.lsu_error_mscause_r, 2);
    chk("dir_addr",  bus.lsu_error_addr_r, 32'h2000_0001);
    step();
    chk("dir_pend",  bus.err_pending, 1);
    chk("dir_cnt",   bus.err_cnt, 1);

    // DMA fault never reports
    set_fault(0, 1, 4'd1, 32'h1234_0000); bus.lsu_pkt_dma_d = 1;
    step(); clear_in(); step();
    chk("dma_valid", bus.lsu_error_valid_r, 0);
    step();
    chk("dma_cnt",   bus.err_cnt, 1);

    // second error without ack leaves capture A; with ack it takes C
    set_fault(0, 1, 4'd3, 32'h3000_0000);
    step(); clear_in(); step(); step();
    chk("noack_capa", bus.err_cap_addr, 32'h2000_0001);
    set_fault(0, 0, 4'd5, 32'h4000_0040);
    step(); clear_in(); step();
    bus.err_ack = 1;
    step();
    bus.err_ack = 0;
    chk("ack_capa", bus.err_cap_addr, 32'h4000_0040);
    chk("ack_pend", bus.err_pending, 1);
    bus.err_ack = 1;
    step();
    bus.err_ack = 0;
    chk("ack_clear", bus.err_pending, 0);
    chk("ack_hold",  bus.err_cap_addr, 32'h4000_0040);

    // fault in M killed by flush; fault in R during flush shown then cleared
    set_fault(1, 0, 4'd7, 32'h5000_0000);
    step();
    clear_in(); bus.dec_tlu_flush_lower_r = 1;
    step();
    bus.dec_tlu_flush_lower_r = 0;
    chk("flush_m", bus.lsu_error_valid_r, 0);
    set_fault(1, 0, 4'd7, 32'h5000_0004);
    step(); clear_in(); step();
    bus.dec_tlu_flush_lower_r = 1;
    chk("flush_r_seen", bus.lsu_error_valid_r, 1);
    step();
    bus.dec_tlu_flush_lower_r = 0;
    chk("flush_r_gone", bus.lsu_error_valid_r, 0);

    // freeze 3 cycles with an error in R: reported each cycle, counted once
    set_fault(0, 1, 4'd4, 32'h6000_0000);
    step(); clear_in(); step();
    cnt0 = md_cnt;
    for (int i = 0; i < 3; i++) begin
      set_fault(1, 0, 4'(i), 32'h7000_0000 + 32'(i));
      bus.lsu_freeze = 1;
      step();
      chk("frz_valid", bus.lsu_error_valid_r, 1);
      chk("frz_addr",  bus.lsu_error_addr_r, 32'h6000_0000);
    end
    clear_in();
    step();
    chk("frz_cnt", bus.err_cnt, 64'(cnt0 + 1));

    // fast-int with both fir sources: DCCM wins
    bus.lsu_pkt_valid_d = 1; bus.lsu_pkt_fast_int_d = 1;
    bus.fir_dccm_access_error_d = 1; bus.fir_nondccm_access_error_d = 1;
    step(); clear_in(); step();
    chk("fir_both", bus.lsu_fir_error_r, 2'b01);

    // randomized stream with a mid-stream async reset
    for (int i = 0; i < 400; i++) begin
      rand_in();
      step();
      if (i == 200) begin
        #2 rst = 1;
        #1 check_zero("async_rst");
        model_reset();
        clear_in();
        @(negedge clk);
        rst = 0;
      end
    end

    // saturation of the error counter
    clear_in();
    for (int i = 0; i < 262; i++) begin
      set_fault(i[0], i[1], 4'(i), 32'(i));
      step();
    end
    chk("cnt_sat", bus.err_cnt, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/el2_lsu_fault_pipe.md
# el2_lsu_fault_pipe

Pipelines the per-access fault results from the LSU address checker, produced in D, through M to R. Presents a single architectural LSU error packet to the trap logic in R, plus a sticky first-error capture register for debug/software. Sits directly downstream of the address-check stage and upstream of the TLU exception interface. Honours pipeline freeze and lower flush.

## Interface
- `AW`, 32: address width carried with the error.
- `CNT_W`, 8: width of the saturating reported-error counter.

- `clk`  in  1  core clock
- `rst`  in  1  reset; asynchronous, active-high
- `lsu_pkt_valid_d`  in  1  LSU packet valid in D
- `lsu_pkt_store_d`  in  1  packet is a store (0 = load)
- `lsu_pkt_dma_d`  in  1  DMA access; never reports errors
- `lsu_pkt_fast_int_d`  in  1  fast-interrupt vector fetch
- `access_fault_d`  in  1  access fault from address check
- `misaligned_fault_d`  in  1  misaligned fault from address check
- `exc_mscause_d`  in  4  mscause for the fault
- `fir_dccm_access_error_d`  in  1  fast-int DCCM access error
- `fir_nondccm_access_error_d`  in  1  fast-int non-DCCM access error
- `start_addr_d`  in  AW  access start address
- `lsu_freeze`  in  1  hold all stage registers
- `dec_tlu_flush_lower_r`  in  1  kill M and R contents
- `err_ack`  in  1  software/debug acknowledge; clears sticky capture
- `lsu_error_valid_r`  out  1  exception reported in R
- `lsu_error_misaligned_r`  out  1  1 = misaligned, 0 = access fault
- `lsu_error_store_r`  out  1  faulting instruction is a store
- `lsu_error_mscause_r`  out  4  mscause
- `lsu_error_addr_r`  out  AW  faulting address (mtval)
- `lsu_fir_error_r`  out  2  01 DCCM, 10 non-DCCM, 00 none
- `err_pending`  out  1  sticky capture holds an unacknowledged error
- `err_cap_mscause`  out  4  captured mscause
- `err_cap_addr`  out  AW  captured address
- `err_cnt`  out  CNT_W  saturating count of reported errors

## Operation
- M stage load, when `lsu_freeze`=0:
  - `m_valid` ← `lsu_pkt_valid_d & ~lsu_pkt_dma_d & ~dec_tlu_flush_lower_r`.
  - `m_fault` ← `access_fault_d | misaligned_fault_d`.
  - `m_mis` ← `misaligned_fault_d`. Misaligned has priority; mscause is already prioritised upstream.
  - `m_fir` ← `fir_dccm ? 01 : fir_nondccm ? 10 : 00`, gated by `lsu_pkt_fast_int_d`.
  - Store, mscause and address are also loaded.
- R stage load, when `lsu_freeze`=0: `r_*` ← `m_*`, with `r_valid` ← `m_valid & ~dec_tlu_flush_lower_r`.
- Flush: `dec_tlu_flush_lower_r` clears `m_valid` and `r_valid` on the next edge. It overrides freeze. Payload registers need not clear.
- Freeze (no flush): every stage register holds.
- Outputs are combinational from R registers:
  - `lsu_error_valid_r` = `r_valid & r_fault`.
  - `lsu_fir_error_r` = `r_valid ? r_fir : 00`.
  - `lsu_error_misaligned_r`, `lsu_error_store_r`, `lsu_error_mscause_r` and `lsu_error_addr_r` are forced to 0 when `lsu_error_valid_r`=0.
- Sticky capture:
  - On a cycle with `lsu_error_valid_r`=1 and (`err_pending`=0 or `err_ack`=1): capture mscause/addr and set `err_pending`.
  - `err_ack` alone clears `err_pending`; captured fields hold their value.
  - While pending and not acked, later errors do not overwrite the capture.
- Counter: `err_cnt` +1 on each cycle with `lsu_error_valid_r & ~lsu_freeze`. It saturates at all-ones and is cleared only by reset.
- A frozen R error is reported (valid stays high) every cycle, but is counted/captured once. Capture is also blocked while `lsu_freeze`=1.

## Timing
- D→R latency: 2 unfrozen edges. A fault in D at cycle n gives `lsu_error_valid_r` in n+2.
- `err_pending`/capture are visible at n+3; `err_cnt` increments at n+3.
- Reset: all stage valids, outputs, `err_pending`, captured fields and `err_cnt` are 0, asynchronously.
- Reset deasserted mid-stream: the first D packet after deassertion is the first one tracked.
- Simultaneous flush and D valid: the D packet is dropped (it is not loaded into M).

## Test plan
- Load, misaligned, mscause=2, addr=0x2000_0001 in D → two cycles later: valid_r=1, misaligned=1, store=0, mscause=2, addr=0x2000_0001. Next cycle: err_pending=1, err_cnt=1.
- DMA packet with access_fault_d=1 → no valid_r, err_cnt unchanged.
- Fault in M and flush asserted → valid_r stays 0 next cycle. A fault in R during flush is reported that cycle, then cleared.
- Freeze 3 cycles with error in R → valid_r high 3 cycles, err_cnt +1 only; D changes are ignored until freeze drops.
- Pending capture (addr A), second error (addr B) without ack → capture stays A. Second error coincident with err_ack → capture becomes B, pending stays 1.
- Fast-int packet with both fir inputs high → lsu_fir_error_r=01. err_cnt forced to 255 plus one more error → stays 255. Async rst mid-stream → all outputs 0 immediately.
